// File: rtl/cycle_sequencer_pkg.sv
// Shared NBBPU definitions: opcode constants, external cycle-state encodings
// and the opcode classification used by the cycle sequencer.
package cycle_sequencer_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_LSL = 4'b0110;
    localparam logic [3:0] OP_LSR = 4'b0111;
    localparam logic [3:0] OP_EQU = 4'b1000;
    localparam logic [3:0] OP_NEQ = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1011;
    localparam logic [3:0] OP_LOD = 4'b1100;
    localparam logic [3:0] OP_STR = 4'b1101;
    localparam logic [3:0] OP_SEL = 4'b1110;
    localparam logic [3:0] OP_SEU = 4'b1111;

    typedef enum logic [1:0] {
        CYC_FETCH   = 2'b00,
        CYC_DECODE  = 2'b01,
        CYC_EXECUTE = 2'b10,
        CYC_STORE   = 2'b11
    } cycle_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOD) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Handshake and status bundle between the cycle sequencer (master) and the
// NBBPU controller / memories (slave).
interface cycle_sequencer_if #(
    parameter int COUNT_WIDTH = 16
);
    logic [3:0]             opcode;
    logic                   instruction_ready;
    logic                   data_ready;
    logic                   halt;
    logic [1:0]             state;
    logic                   instruction_request;
    logic                   data_request;
    logic                   retire;
    logic [COUNT_WIDTH-1:0] instruction_count;
    logic                   halted;
    logic                   fault;

    modport master (
        input  opcode, instruction_ready, data_ready, halt,
        output state, instruction_request, data_request, retire,
               instruction_count, halted, fault
    );

    modport slave (
        output opcode, instruction_ready, data_ready, halt,
        input  state, instruction_request, data_request, retire,
               instruction_count, halted, fault
    );
endinterface

// File: rtl/cycle_sequencer_wait_timer.sv
// Counts consecutive wait cycles of one handshake; expired flags the cycle
// in which the WAIT_LIMIT-th wait would occur.
module wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int              CW   = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0]   LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] cnt_r;

    // Wait-cycle counter, restarted whenever the sequencer changes state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// NBBPU cycle sequencer: FETCH/DECODE/EXECUTE/STORE with ROM/RAM handshake
// stalls, boundary halt, retired-instruction count and wait-timeout trap.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    cycle_sequencer_if.master  bus
);
    localparam logic [2:0] S_FETCH   = 3'b000;
    localparam logic [2:0] S_DECODE  = 3'b001;
    localparam logic [2:0] S_EXECUTE = 3'b010;
    localparam logic [2:0] S_STORE   = 3'b011;
    localparam logic [2:0] S_HALT    = 3'b100;

    logic [2:0]             state_r;
    logic [2:0]             nxt_state_s;
    logic                   fault_r;
    logic                   nxt_fault_s;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [1:0]             state_out_r;
    logic                   ireq_r;
    logic                   dreq_r;
    logic                   retire_r;
    logic                   halted_r;
    logic                   mem_op_s;
    logic                   wait_en_s;
    logic                   expired_s;
    logic                   clear_s;

    assign mem_op_s = is_mem_op(bus.opcode);

    // A wait cycle is a cycle with an outstanding request and no ready
    always_comb begin
        wait_en_s = 1'b0;
        case (state_r)
            S_FETCH:   wait_en_s = !bus.instruction_ready;
            S_EXECUTE: wait_en_s = mem_op_s && !bus.data_ready;
            default:   wait_en_s = 1'b0;
        endcase
    end

    assign clear_s = (nxt_state_s != state_r);

    wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear_s),
        .enable  (wait_en_s),
        .expired (expired_s)
    );

    // Next-state and fault decision; ready always takes priority over expiry
    always_comb begin
        nxt_state_s = state_r;
        nxt_fault_s = fault_r;
        case (state_r)
            S_FETCH: begin
                if (bus.instruction_ready) begin
                    nxt_state_s = S_DECODE;
                end else if (expired_s) begin
                    nxt_state_s = S_HALT;
                    nxt_fault_s = 1'b1;
                end else begin
                    nxt_state_s = S_FETCH;
                end
            end
            S_DECODE: nxt_state_s = S_EXECUTE;
            S_EXECUTE: begin
                if (!mem_op_s || bus.data_ready) begin
                    nxt_state_s = S_STORE;
                end else if (expired_s) begin
                    nxt_state_s = S_HALT;
                    nxt_fault_s = 1'b1;
                end else begin
                    nxt_state_s = S_EXECUTE;
                end
            end
            S_STORE: begin
                if (bus.halt) begin
                    nxt_state_s = S_HALT;
                end else begin
                    nxt_state_s = S_FETCH;
                end
            end
            S_HALT: begin
                if (!bus.halt && !fault_r) begin
                    nxt_state_s = S_FETCH;
                end else begin
                    nxt_state_s = S_HALT;
                end
            end
            default: nxt_state_s = S_FETCH;
        endcase
    end

    // State, sticky fault, counter and Moore outputs registered from next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= S_FETCH;
            fault_r     <= 1'b0;
            count_r     <= '0;
            state_out_r <= CYC_FETCH;
            ireq_r      <= 1'b1;
            dreq_r      <= 1'b0;
            retire_r    <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            fault_r     <= nxt_fault_s;
            if (state_r == S_STORE) begin
                count_r <= count_r + COUNT_WIDTH'(1);
            end else begin
                count_r <= count_r;
            end
            state_out_r <= (nxt_state_s == S_HALT) ? CYC_FETCH : nxt_state_s[1:0];
            ireq_r      <= (nxt_state_s == S_FETCH);
            dreq_r      <= (nxt_state_s == S_EXECUTE) && mem_op_s;
            retire_r    <= (nxt_state_s == S_STORE);
            halted_r    <= (nxt_state_s == S_HALT);
        end
    end

    assign bus.state               = state_out_r;
    assign bus.instruction_request = ireq_r;
    assign bus.data_request        = dreq_r;
    assign bus.retire              = retire_r;
    assign bus.instruction_count   = count_r;
    assign bus.halted              = halted_r;
    assign bus.fault               = fault_r;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Table-driven bench for cycle_sequencer with a scoreboard of expected
// post-edge output words; reset corner cases are hand-written sequences.
module tb_cycle_sequencer;
    import cycle_sequencer_pkg::*;

    localparam int WL  = 4;
    localparam int CWD = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    cycle_sequencer_if #(.COUNT_WIDTH(CWD)) bus ();

    cycle_sequencer #(.WAIT_LIMIT(WL), .COUNT_WIDTH(CWD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic        ir;
        logic        dr;
        logic        hl;
        logic [10:0] exp;
    } vec_t;

    vec_t        p1[$];
    vec_t        p2[$];
    logic [10:0] sb[$];
    int          compared   = 0;
    int          mismatched = 0;

    // {state, instruction_request, data_request, retire, halted, fault, count}
    function automatic logic [10:0] pk(input logic [1:0] st, input logic iq, input logic dq,
                                       input logic rt, input logic ht, input logic ft,
                                       input logic [3:0] cnt);
        return {st, iq, dq, rt, ht, ft, cnt};
    endfunction

    function automatic logic [10:0] xf(input logic [3:0] c);
        return pk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [10:0] xd(input logic [3:0] c);
        return pk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [10:0] xe(input logic d, input logic [3:0] c);
        return pk(2'b10, 1'b0, d, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [10:0] xs(input logic [3:0] c);
        return pk(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [10:0] xh(input logic f, input logic [3:0] c);
        return pk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, f, c);
    endfunction

    function automatic vec_t v(input logic [3:0] op, input logic ir, input logic dr,
                               input logic hl, input logic [10:0] exp);
        vec_t t;
        t.op = op; t.ir = ir; t.dr = dr; t.hl = hl; t.exp = exp;
        return t;
    endfunction

    task automatic compare(input string name, input int idx);
        logic [10:0] got;
        logic [10:0] exp;
        got = {bus.state, bus.instruction_request, bus.data_request, bus.retire,
               bus.halted, bus.fault, bus.instruction_count};
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL %s #%0d: scoreboard empty, got %b", name, idx, got);
        end else begin
            exp = sb.pop_front();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL %s #%0d: got %b required %b (st,ireq,dreq,ret,hlt,flt,cnt)",
                         name, idx, got, exp);
            end
        end
    endtask

    task automatic apply(input string name, input int idx, input vec_t t);
        bus.opcode            = t.op;
        bus.instruction_ready = t.ir;
        bus.data_ready        = t.dr;
        bus.halt              = t.hl;
        sb.push_back(t.exp);
        @(posedge clock);
        #1;
        compare(name, idx);
    endtask

    // Assert reset asynchronously, check outputs before any edge, release after one edge
    task automatic reset_check(input string name);
        bus.instruction_ready = 1'b0;
        bus.data_ready        = 1'b0;
        bus.halt              = 1'b0;
        reset = 1'b1;
        sb.push_back(xf(4'd0));
        #1;
        compare(name, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d", compared);
        $fatal(1);
    end

    initial begin
        // ADD with no waits; data_ready held high is ignored outside memory EXECUTE
        p1.push_back(v(OP_ADD, 1'b1, 1'b1, 1'b0, xd(4'd0)));
        p1.push_back(v(OP_ADD, 1'b1, 1'b1, 1'b0, xe(1'b0, 4'd0)));
        p1.push_back(v(OP_ADD, 1'b1, 1'b1, 1'b0, xs(4'd0)));
        p1.push_back(v(OP_ADD, 1'b1, 1'b1, 1'b0, xf(4'd1)));
        // LOD: 2 fetch waits, 3 data waits, ready lands on the limit cycle
        p1.push_back(v(OP_LOD, 1'b0, 1'b0, 1'b0, xf(4'd1)));
        p1.push_back(v(OP_LOD, 1'b0, 1'b0, 1'b0, xf(4'd1)));
        p1.push_back(v(OP_LOD, 1'b1, 1'b0, 1'b0, xd(4'd1)));
        p1.push_back(v(OP_LOD, 1'b1, 1'b0, 1'b0, xe(1'b1, 4'd1)));
        p1.push_back(v(OP_LOD, 1'b1, 1'b0, 1'b0, xe(1'b1, 4'd1)));
        p1.push_back(v(OP_LOD, 1'b1, 1'b0, 1'b0, xe(1'b1, 4'd1)));
        p1.push_back(v(OP_LOD, 1'b1, 1'b0, 1'b0, xe(1'b1, 4'd1)));
        p1.push_back(v(OP_LOD, 1'b1, 1'b1, 1'b0, xs(4'd1)));
        p1.push_back(v(OP_LOD, 1'b1, 1'b1, 1'b0, xf(4'd2)));
        // STR with halt raised during a fetch wait; parks after STORE
        p1.push_back(v(OP_STR, 1'b0, 1'b0, 1'b1, xf(4'd2)));
        p1.push_back(v(OP_STR, 1'b1, 1'b0, 1'b1, xd(4'd2)));
        p1.push_back(v(OP_STR, 1'b1, 1'b0, 1'b1, xe(1'b1, 4'd2)));
        p1.push_back(v(OP_STR, 1'b1, 1'b1, 1'b1, xs(4'd2)));
        p1.push_back(v(OP_STR, 1'b1, 1'b1, 1'b1, xh(1'b0, 4'd3)));
        p1.push_back(v(OP_STR, 1'b1, 1'b1, 1'b1, xh(1'b0, 4'd3)));
        p1.push_back(v(OP_ADD, 1'b0, 1'b0, 1'b0, xf(4'd3)));
        // Fetch timeout after WL wait cycles; fault keeps it parked
        p1.push_back(v(OP_ADD, 1'b0, 1'b0, 1'b0, xf(4'd3)));
        p1.push_back(v(OP_ADD, 1'b0, 1'b0, 1'b0, xf(4'd3)));
        p1.push_back(v(OP_ADD, 1'b0, 1'b0, 1'b0, xf(4'd3)));
        p1.push_back(v(OP_ADD, 1'b0, 1'b0, 1'b0, xh(1'b1, 4'd3)));
        p1.push_back(v(OP_ADD, 1'b0, 1'b0, 1'b0, xh(1'b1, 4'd3)));
        p1.push_back(v(OP_ADD, 1'b1, 1'b1, 1'b0, xh(1'b1, 4'd3)));

        // 17 back-to-back ADDs: count wraps to 0 after 16, then reads 1
        for (int i = 0; i < 17; i++) begin
            p2.push_back(v(OP_ADD, 1'b1, 1'b0, 1'b0, xd(4'(i))));
            p2.push_back(v(OP_ADD, 1'b1, 1'b0, 1'b0, xe(1'b0, 4'(i))));
            p2.push_back(v(OP_ADD, 1'b1, 1'b0, 1'b0, xs(4'(i))));
            p2.push_back(v(OP_ADD, 1'b1, 1'b0, 1'b0, xf(4'((i + 1) % 16))));
        end
        // STR left waiting in EXECUTE for the reset sequence below
        p2.push_back(v(OP_STR, 1'b1, 1'b0, 1'b0, xd(4'd1)));
        p2.push_back(v(OP_STR, 1'b0, 1'b0, 1'b0, xe(1'b1, 4'd1)));

        bus.opcode            = OP_ADD;
        bus.instruction_ready = 1'b0;
        bus.data_ready        = 1'b0;
        bus.halt              = 1'b0;
        #2;
        reset_check("reset_initial");

        foreach (p1[i]) apply("phase1", i, p1[i]);
        reset_check("reset_after_fault");

        foreach (p2[i]) apply("phase2", i, p2[i]);
        #2;
        reset_check("reset_in_str_execute");

        apply("restart_fetch", 0, v(OP_ADD, 1'b1, 1'b0, 1'b0, xd(4'd0)));
        apply("restart_decode", 0, v(OP_ADD, 1'b1, 1'b0, 1'b0, xe(1'b0, 4'd0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
